branch_resolver: RTL
====================

// Module: branch_resolver
// PURPOSE
//   Misprediction detector feeding the program counter's redirect inputs. Tracks each fetched PC and
//   its predicted next PC through IF->ID->EX. Checks direct jumps in ID and branches/JR in EX.
//   On a mismatch, drives Jump_Failed/Branch_Failed with the correct PC and flushes wrong-path stages.
// PARAMETERS
//   WORD_SIZE   16   PC / address width
//   CNT_W       16   width of performance counters (only with BR_PERF_CNT_EN)
// PORTS
//   clk                 in   1          clock, rising edge
//   reset_n             in   1          synchronous, active-low reset
//   stall               in   1          hazard stall: IF/ID held, EX receives bubble
//   IF_pc               in   WORD_SIZE  PC fetched this cycle
//   IF_pred_pc          in   WORD_SIZE  next PC chosen by predictor for IF_pc
//   IF_valid            in   1          IF holds a real instruction
//   ID_is_jump          in   1          ID instr is direct JMP/JAL
//   ID_jump_target      in   WORD_SIZE  decoded jump target
//   EX_is_branch        in   1          EX instr is conditional branch
//   EX_branch_taken     in   1          branch outcome
//   EX_branch_target    in   WORD_SIZE  taken target
//   EX_is_jr            in   1          EX instr is JPR/JRL
//   EX_jr_target        in   WORD_SIZE  register target
//   Jump_Failed         out  1          ID jump mispredicted
//   Jump_Correct_PC     out  WORD_SIZE  = ID_jump_target
//   Branch_Failed       out  1          EX branch/JR mispredicted
//   Branch_Correct_PC   out  WORD_SIZE  actual next PC of EX instr
//   flush_ID            out  1          kill instr entering ID next cycle
//   flush_EX            out  1          kill instr entering EX next cycle
//   br_cnt, br_miss_cnt, jmp_miss_cnt  out  CNT_W  perf counters
// BEHAVIOUR
//   - State: {v,pc,pred}_ID and {v,pc,pred}_EX tracking registers. Reset: v_ID=v_EX=0, counters 0.
//     All fail/flush outputs are therefore 0 during and after reset; correct-PC outputs don't-care.
//   - Fail/flush outputs are combinational from tracking regs + stage inputs; PC samples them same edge.
//   - Branch actual = EX_is_jr ? EX_jr_target : EX_branch_taken ? EX_branch_target : pc_EX+1
//     (mod 2^WORD_SIZE; 0xFFFF+1 = 0x0000).
//   - Branch_Failed = v_EX & (EX_is_branch|EX_is_jr) & (pred_EX != actual); Branch_Correct_PC = actual.
//   - Jump_Failed = v_ID & ID_is_jump & (pred_ID != ID_jump_target) & ~Branch_Failed (EX is older, wins).
//   - flush_ID = Branch_Failed | Jump_Failed; flush_EX = Branch_Failed.
//   - Update priority at posedge: reset > Branch_Failed > Jump_Failed > stall > advance.
//     Branch_Failed: v_ID<=0, v_EX<=0.
//     Jump_Failed:   v_ID<=0; EX<=ID with pred_EX<=ID_jump_target.
//     stall:         ID held; v_EX<=0 (bubble).
//     advance:       ID<={IF_valid,IF_pc,IF_pred_pc}; EX<=ID.
//   - Fail overrides stall. Each mispredict pulses exactly one cycle; invalidation prevents refiring.
//   - Reset mid-redirect: wins, discards all tracking.
// CONFIGURATION
//   BR_PERF_CNT_EN defined: br_cnt +1 per resolved EX branch/JR (v_EX & type) when not stalled-out;
//     br_miss_cnt +1 per Branch_Failed; jmp_miss_cnt +1 per Jump_Failed.
//     Counters saturate at 2^CNT_W-1 and update at posedge.
//   Undefined: counter logic absent, counter ports tied to 0.
// TESTING
//   1 reset_n=0 two cycles, EX_is_branch=1 mismatched -> no fail/flush; counters 0.
//   2 IF 0x0010 pred 0x0011, EX taken target 0x0020 -> Branch_Failed=1 one cycle, Correct=0x0020,
//     flush_ID=flush_EX=1, no refire next cycle.
//   3 JMP at 0x0030 pred 0x0031 target 0x0100 -> Jump_Failed=1 one cycle, Correct=0x0100; pred 0x0100 -> none.
//   4 same cycle EX branch mispredict and ID jump mispredict -> only Branch_Failed; jump instr squashed.
//   5 branch at 0xFFFF not-taken pred 0x0000 -> no fail; pred 0xFFFF -> Branch_Failed, Correct=0x0000.
//   6 branch held in ID with stall=1 three cycles -> EX bubbles, one resolution after release;
//     br_cnt +1 exactly (EN build).

Source files
------------

// File: rtl/branch_resolver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : branch_resolver                                               |
// | Function : Tracks fetched PC / predicted PC through IF->ID->EX, detects   |
// |            jump (ID) and branch/JR (EX) mispredictions, drives redirect  |
// |            and flush. Optional perf counters under `BR_PERF_CNT_EN.     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module branch_resolver #(
    parameter int WORD_SIZE = 16,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 stall,
    input  logic [WORD_SIZE-1:0] IF_pc,
    input  logic [WORD_SIZE-1:0] IF_pred_pc,
    input  logic                 IF_valid,
    input  logic                 ID_is_jump,
    input  logic [WORD_SIZE-1:0] ID_jump_target,
    input  logic                 EX_is_branch,
    input  logic                 EX_branch_taken,
    input  logic [WORD_SIZE-1:0] EX_branch_target,
    input  logic                 EX_is_jr,
    input  logic [WORD_SIZE-1:0] EX_jr_target,
    output logic                 Jump_Failed,
    output logic [WORD_SIZE-1:0] Jump_Correct_PC,
    output logic                 Branch_Failed,
    output logic [WORD_SIZE-1:0] Branch_Correct_PC,
    output logic                 flush_ID,
    output logic                 flush_EX,
    output logic [CNT_W-1:0]     br_cnt,
    output logic [CNT_W-1:0]     br_miss_cnt,
    output logic [CNT_W-1:0]     jmp_miss_cnt
);

    logic                 r_v_id;
    logic [WORD_SIZE-1:0] r_pc_id;
    logic [WORD_SIZE-1:0] r_pred_id;
    logic                 r_v_ex;
    logic [WORD_SIZE-1:0] r_pc_ex;
    logic [WORD_SIZE-1:0] r_pred_ex;

    logic [WORD_SIZE-1:0] w_actual;
    logic                 w_br_resolved;
    logic                 w_branch_failed;
    logic                 w_jump_failed;

    // Outputs held quiet while reset is asserted so a redirect never escapes a reset cycle.
    always_comb begin
        w_actual        = EX_is_jr        ? EX_jr_target     :
                          EX_branch_taken ? EX_branch_target :
                                            r_pc_ex + WORD_SIZE'(1);
        w_br_resolved   = reset_n & r_v_ex & (EX_is_branch | EX_is_jr);
        w_branch_failed = w_br_resolved & (r_pred_ex != w_actual);
        w_jump_failed   = reset_n & r_v_id & ID_is_jump &
                          (r_pred_id != ID_jump_target) & ~w_branch_failed;
    end

    assign Branch_Failed     = w_branch_failed;
    assign Branch_Correct_PC = w_actual;
    assign Jump_Failed       = w_jump_failed;
    assign Jump_Correct_PC   = ID_jump_target;
    assign flush_ID          = w_branch_failed | w_jump_failed;
    assign flush_EX          = w_branch_failed;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_v_id <= 1'b0;
            r_v_ex <= 1'b0;
        end else if (w_branch_failed) begin
            r_v_id <= 1'b0;
            r_v_ex <= 1'b0;
        end else if (w_jump_failed) begin
            // The jump itself moves on to EX already carrying its now-correct successor.
            r_v_id    <= 1'b0;
            r_v_ex    <= r_v_id;
            r_pc_ex   <= r_pc_id;
            r_pred_ex <= ID_jump_target;
        end else if (stall) begin
            r_v_ex <= 1'b0;
        end else begin
            r_v_id    <= IF_valid;
            r_pc_id   <= IF_pc;
            r_pred_id <= IF_pred_pc;
            r_v_ex    <= r_v_id;
            r_pc_ex   <= r_pc_id;
            r_pred_ex <= r_pred_id;
        end
    end

`ifdef BR_PERF_CNT_EN
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    logic [CNT_W-1:0] r_br_cnt;
    logic [CNT_W-1:0] r_br_miss_cnt;
    logic [CNT_W-1:0] r_jmp_miss_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_br_cnt       <= '0;
            r_br_miss_cnt  <= '0;
            r_jmp_miss_cnt <= '0;
        end else begin
            if (w_br_resolved && r_br_cnt != C_CNT_MAX)
                r_br_cnt <= r_br_cnt + CNT_W'(1);
            if (w_branch_failed && r_br_miss_cnt != C_CNT_MAX)
                r_br_miss_cnt <= r_br_miss_cnt + CNT_W'(1);
            if (w_jump_failed && r_jmp_miss_cnt != C_CNT_MAX)
                r_jmp_miss_cnt <= r_jmp_miss_cnt + CNT_W'(1);
        end
    end

    assign br_cnt       = r_br_cnt;
    assign br_miss_cnt  = r_br_miss_cnt;
    assign jmp_miss_cnt = r_jmp_miss_cnt;
`else
    assign br_cnt       = '0;
    assign br_miss_cnt  = '0;
    assign jmp_miss_cnt = '0;
`endif

endmodule
`default_nettype wire
